// File: rtl/addpkg.sv
// Shared types for the single-precision add/sub datapath.
// Operand-check special-case codes travel with every result.
package addpkg;
  typedef enum logic [2:0] {
    NO_ERR      = 3'd0,
    ZERO_OP_ERR = 3'd1,
    INF_ERR     = 3'd2,
    NAN_ERR     = 3'd3,
    ZERO_ERR    = 3'd4
  } i_err_t;
endpackage

// File: rtl/norm_round_if.sv
// Upstream operand and downstream result handshakes of norm_round.
// slave is the stage side, master is the environment side.
interface norm_round_if;
  import addpkg::*;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [27:0] sum_i;
  logic [30:0] nz_op_i;
  i_err_t      err_i;
  logic        valid_o;
  logic        ready_i;
  logic        sign_o;
  logic [7:0]  exp_o;
  logic [26:0] sig_untrunc_o;
  logic        carry_o;
  logic [30:0] nz_op_o;
  i_err_t      err_o;

  modport slave (
    input  valid_i, sign_i, exp_i, sum_i,
    input  nz_op_i, err_i, ready_i,
    output ready_o, valid_o, sign_o, exp_o,
    output sig_untrunc_o, carry_o, nz_op_o, err_o
  );

  modport master (
    output valid_i, sign_i, exp_i, sum_i,
    output nz_op_i, err_i, ready_i,
    input  ready_o, valid_o, sign_o, exp_o,
    input  sig_untrunc_o, carry_o, nz_op_o, err_o
  );
endinterface

// File: rtl/norm_round.sv
// Iterative normalize (1 bit/cycle) and round-to-nearest-even stage
// for the single-precision add/sub datapath.
module norm_round
  import addpkg::*;
#(
  parameter int MAX_SHIFT = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  norm_round_if.slave io
);
  localparam int CW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [2:0] {
    IDLE, EVAL, SHIFT, ROUND, DONE
  } st_t;

  st_t         st_q, st_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  e_q, e_d;
  logic [27:0] sig_q, sig_d;
  logic        carry_q, carry_d;
  logic [30:0] nz_q, nz_d;
  i_err_t      err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0]  e0;
  logic [7:0]  e_m;
  logic [27:0] sh;
  logic        ru;
  logic [24:0] t;
  logic        spec;

  always_comb begin
    e0   = (exp_q == 8'd0) ? 8'd1 : exp_q;
    e_m  = e_q - 8'd1;
    sh   = {sig_q[26:0], 1'b0};
    ru   = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
    t    = {1'b0, sig_q[26:3]} + {24'd0, ru};
    spec = 1'b0;
    unique case (1'b1)
      err_q == ZERO_OP_ERR,
      err_q == INF_ERR,
      err_q == NAN_ERR,
      err_q == ZERO_ERR: spec = 1'b1;
      default:           spec = 1'b0;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    e_d     = e_q;
    sig_d   = sig_q;
    carry_d = carry_q;
    nz_d    = nz_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (st_q)
      IDLE: if (io.valid_i) begin
        sign_d  = io.sign_i;
        exp_d   = io.exp_i;
        sig_d   = io.sum_i;
        nz_d    = io.nz_op_i;
        err_d   = io.err_i;
        carry_d = 1'b0;
        st_d    = EVAL;
      end
      EVAL: begin
        e_d   = e0;
        cnt_d = '0;
        if (spec) begin
          st_d = DONE;
        end else if (sig_q == 28'd0) begin
          err_d  = ZERO_ERR;
          sign_d = 1'b0;
          exp_d  = 8'd0;
          st_d   = DONE;
        end else if (sig_q[27]) begin
          // Right shift keeps the dropped bit sticky.
          sig_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
          e_d   = e0 + 8'd1;
          st_d  = ROUND;
          if (e0 >= 8'd254) begin
            exp_d   = 8'hFF;
            sig_d   = '0;
            carry_d = 1'b1;
            st_d    = DONE;
          end
        end else if (sig_q[26] || e0 == 8'd1) begin
          st_d = ROUND;
        end else begin
          st_d = SHIFT;
        end
      end
      SHIFT: begin
        sig_d = sh;
        e_d   = e_m;
        cnt_d = cnt_q + 1'b1;
        if (sh[26] || e_m == 8'd1 ||
            cnt_q == CW'(MAX_SHIFT - 1))
          st_d = ROUND;
      end
      ROUND: begin
        st_d = DONE;
        if (t[24]) begin
          sig_d = 28'h4000000;
          exp_d = e_q + 8'd1;
          if (e_q >= 8'd254) begin
            exp_d   = 8'hFF;
            sig_d   = '0;
            carry_d = 1'b1;
          end
        end else begin
          sig_d = {1'b0, t[23:0], 3'b000};
          exp_d = t[23] ? e_q : 8'd0;
        end
      end
      DONE: if (io.ready_i) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      e_q     <= '0;
      sig_q   <= '0;
      carry_q <= 1'b0;
      nz_q    <= '0;
      err_q   <= NO_ERR;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      e_q     <= e_d;
      sig_q   <= sig_d;
      carry_q <= carry_d;
      nz_q    <= nz_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.ready_o       = (st_q == IDLE);
  assign io.valid_o       = (st_q == DONE);
  assign io.sign_o        = sign_q;
  assign io.exp_o         = exp_q;
  assign io.sig_untrunc_o = sig_q[26:0];
  assign io.carry_o       = carry_q;
  assign io.nz_op_o       = nz_q;
  assign io.err_o         = err_q;
endmodule

// File: tb/tb_norm_round.sv
// Directed scoreboard bench for norm_round: latency, RNE,
// overflow, denormal, special, backpressure and mid-op reset.
module tb_norm_round;
  import addpkg::*;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] sig;
    logic        carry;
    logic [30:0] nz;
    i_err_t      err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  norm_round_if bus ();

  norm_round #(.MAX_SHIFT(26)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic start(input logic s, input logic [7:0] e,
                       input logic [27:0] sum, input logic [30:0] nz,
                       input i_err_t er);
    bus.sign_i  = s;
    bus.exp_i   = e;
    bus.sum_i   = sum;
    bus.nz_op_i = nz;
    bus.err_i   = er;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    chk("busy_ready", 64'(bus.ready_o), 64'd0);
  endtask

  task automatic push(input logic s, input logic [7:0] e,
                      input logic [26:0] sig, input logic c,
                      input logic [30:0] nz, input i_err_t er,
                      input int lat);
    exp_t x;
    x.sign = s; x.exp = e; x.sig = sig; x.carry = c;
    x.nz = nz; x.err = er; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic cmp(input exp_t x, input string p);
    chk({p, "_sign"}, 64'(bus.sign_o), 64'(x.sign));
    chk({p, "_exp"}, 64'(bus.exp_o), 64'(x.exp));
    chk({p, "_sig"}, 64'(bus.sig_untrunc_o), 64'(x.sig));
    chk({p, "_carry"}, 64'(bus.carry_o), 64'(x.carry));
    chk({p, "_nz"}, 64'(bus.nz_op_o), 64'(x.nz));
    chk({p, "_err"}, 64'(bus.err_o), 64'(x.err));
  endtask

  task automatic finish(input string tag, input int hold);
    exp_t x;
    int n;
    n = 0;
    chk({tag, "_sb"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      while (!bus.valid_o && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk({tag, "_valid"}, 64'(bus.valid_o), 64'd1);
      chk({tag, "_lat"}, 64'(n), 64'(x.lat));
      cmp(x, tag);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk({tag, "_hold_valid"}, 64'(bus.valid_o), 64'd1);
        cmp(x, {tag, "_hold"});
      end
    end
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_i = 1'b0;
    chk({tag, "_rel_valid"}, 64'(bus.valid_o), 64'd0);
    chk({tag, "_rel_ready"}, 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.sign_i  = 1'b0;
    bus.exp_i   = '0;
    bus.sum_i   = '0;
    bus.nz_op_i = '0;
    bus.err_i   = NO_ERR;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_exp", 64'(bus.exp_o), 64'd0);
    chk("rst_sig", 64'(bus.sig_untrunc_o), 64'd0);
    chk("rst_carry", 64'(bus.carry_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_nz", 64'(bus.nz_op_o), 64'd0);

    start(1'b0, 8'd127, 28'h8000000, 31'h3F800000, NO_ERR);
    push(1'b0, 8'd128, 27'h4000000, 1'b0, 31'h3F800000, NO_ERR, 2);
    finish("one_plus_one", 0);

    start(1'b1, 8'd127, 28'h0000008, 31'h12345678, NO_ERR);
    push(1'b1, 8'd104, 27'h4000000, 1'b0, 31'h12345678, NO_ERR, 25);
    finish("cancel", 0);

    start(1'b0, 8'd100, 28'h4000004, 31'h1, NO_ERR);
    push(1'b0, 8'd100, 27'h4000000, 1'b0, 31'h1, NO_ERR, 2);
    finish("rne_even", 0);

    start(1'b0, 8'd100, 28'h400000C, 31'h2, NO_ERR);
    push(1'b0, 8'd100, 27'h4000010, 1'b0, 31'h2, NO_ERR, 2);
    finish("rne_odd", 0);

    start(1'b1, 8'd254, 28'h8000000, 31'h7F000000, NO_ERR);
    push(1'b1, 8'hFF, 27'h0, 1'b1, 31'h7F000000, NO_ERR, 1);
    finish("ovf_carry", 0);

    start(1'b0, 8'd254, 28'h7FFFFFC, 31'h7F7FFFFF, NO_ERR);
    push(1'b0, 8'hFF, 27'h0, 1'b1, 31'h7F7FFFFF, NO_ERR, 2);
    finish("ovf_round", 0);

    start(1'b0, 8'd3, 28'h0100000, 31'h00400000, NO_ERR);
    push(1'b0, 8'd0, 27'h0400000, 1'b0, 31'h00400000, NO_ERR, 4);
    finish("denorm", 0);

    start(1'b0, 8'd1, 28'h3FFFFFC, 31'h5, NO_ERR);
    push(1'b0, 8'd1, 27'h4000000, 1'b0, 31'h5, NO_ERR, 2);
    finish("denorm_rnd", 0);

    start(1'b0, 8'd0, 28'h4000000, 31'h6, NO_ERR);
    push(1'b0, 8'd1, 27'h4000000, 1'b0, 31'h6, NO_ERR, 2);
    finish("denorm_sum", 0);

    start(1'b1, 8'hFF, 28'h4400000, 31'h7FC00000, NAN_ERR);
    push(1'b1, 8'hFF, 27'h4400000, 1'b0, 31'h7FC00000, NAN_ERR, 1);
    finish("nan", 0);

    start(1'b1, 8'd90, 28'h0, 31'h3, NO_ERR);
    push(1'b0, 8'd0, 27'h0, 1'b0, 31'h3, ZERO_ERR, 1);
    finish("zero_sum", 0);

    start(1'b1, 8'd120, 28'h400000C, 31'h77, NO_ERR);
    push(1'b1, 8'd120, 27'h4000010, 1'b0, 31'h77, NO_ERR, 2);
    finish("backpr", 5);

    start(1'b0, 8'd127, 28'h0000008, 31'h9, NO_ERR);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.valid_o), 64'd0);
    chk("mid_rst_ready", 64'(bus.ready_o), 64'd1);
    chk("mid_rst_exp", 64'(bus.exp_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_novalid", 64'(bus.valid_o), 64'd0);
    end

    start(1'b0, 8'd127, 28'h8000000, 31'h3F800000, NO_ERR);
    push(1'b0, 8'd128, 27'h4000000, 1'b0, 31'h3F800000, NO_ERR, 2);
    finish("after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
